// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch stall detection,
// a fixed-latency divider occupancy FSM and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              div_startE,
    input  logic              exceptM,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              div_busy,
    output logic              div_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 2);

    div_state_e       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lwstall, brstall, div_stall;

    // Register 0 is hard-wired, so a zero source index never counts as a hit.
    function automatic logic hit(input logic [REG_AW-1:0] src,
                                 input logic [REG_AW-1:0] dst,
                                 input logic              en);
        return en && (src != '0) && (src == dst);
    endfunction

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (hit(rsE, writeregM, regwriteM))      forwardAE = 2'b10;
        else if (hit(rsE, writeregW, regwriteW)) forwardAE = 2'b01;
        if (hit(rtE, writeregM, regwriteM))      forwardBE = 2'b10;
        else if (hit(rtE, writeregW, regwriteW)) forwardBE = 2'b01;
        forwardAD = hit(rsD, writeregM, regwriteM);
        forwardBD = hit(rtD, writeregM, regwriteM);
    end

    // A jump-register only reads rs, so rt is compared for branches alone.
    always_comb begin
        lwstall = hit(rsD, writeregE, memtoregE & regwriteE) |
                  hit(rtD, writeregE, memtoregE & regwriteE);
        brstall = ((branchD | jrD) & (hit(rsD, writeregE, regwriteE) |
                                      hit(rsD, writeregM, memtoregM))) |
                  (branchD & (hit(rtD, writeregE, regwriteE) |
                              hit(rtD, writeregM, memtoregM)));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exceptM) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (div_startE) begin
                    state_d = S_BUSY;
                    cnt_d   = DIV_LOAD;
                end
                S_BUSY: begin
                    if (cnt_q == '0) state_d = S_DONE;
                    else             cnt_d   = cnt_q - 8'd1;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        div_busy  = (state_q == S_BUSY);
        div_done  = (state_q == S_DONE);
        div_stall = div_busy | ((state_q == S_IDLE) & div_startE);
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (exceptM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (div_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwstall | brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a spec-level model checked every cycle,
// plus hand-computed literal expectations at the key points.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int DIVC = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk, resetn;
  logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, jrD, div_startE, exceptM;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, stallF, stallD, stallE, flushD, flushE, flushM;
  logic div_busy, div_done;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jrD(jrD), .div_startE(div_startE), .exceptM(exceptM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .div_busy(div_busy), .div_done(div_done), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: divider tracked as "busy cycles left" plus a done flag
  int m_busy_left = 0;
  int m_done      = 0;
  int m_cnt       = 0;

  function automatic bit m_hit(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic en);
    return en && (a != 0) && (a == b);
  endfunction

  function automatic bit m_lw();
    return m_hit(rsD, writeregE, memtoregE & regwriteE) || m_hit(rtD, writeregE, memtoregE & regwriteE);
  endfunction

  function automatic bit m_br();
    bit rs_dep, rt_dep;
    rs_dep = m_hit(rsD, writeregE, regwriteE) || m_hit(rsD, writeregM, memtoregM);
    rt_dep = m_hit(rtD, writeregE, regwriteE) || m_hit(rtD, writeregM, memtoregM);
    return (branchD && rs_dep) || (jrD && rs_dep) || (branchD && rt_dep);
  endfunction

  function automatic bit m_div_stall();
    return !exceptM && ((m_busy_left > 0) || (m_busy_left == 0 && !m_done && div_startE));
  endfunction

  function automatic bit m_stallF();
    return !exceptM && (m_div_stall() || m_lw() || m_br());
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy_left = 0;
      m_done      = 0;
      m_cnt       = 0;
    end else begin
      if (m_stallF() && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (exceptM) begin
        m_busy_left = 0;
        m_done      = 0;
      end else if (m_done != 0) begin
        m_done = 0;
      end else if (m_busy_left > 0) begin
        m_busy_left = m_busy_left - 1;
        if (m_busy_left == 0) m_done = 1;
      end else if (div_startE) begin
        m_busy_left = DIVC - 1;
      end
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    logic [1:0] e_fae, e_fbe;
    bit e_sf, e_sd, e_se, e_fd, e_fe, e_fm;
    if (resetn) begin
      e_fae = m_hit(rsE, writeregM, regwriteM) ? 2'b10 : m_hit(rsE, writeregW, regwriteW) ? 2'b01 : 2'b00;
      e_fbe = m_hit(rtE, writeregM, regwriteM) ? 2'b10 : m_hit(rtE, writeregW, regwriteW) ? 2'b01 : 2'b00;
      e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0;
      if (exceptM) begin
        e_fd = 1; e_fe = 1; e_fm = 1;
      end else if (m_div_stall()) begin
        e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
      end else if (m_lw() || m_br()) begin
        e_sf = 1; e_sd = 1; e_fe = 1;
      end
      chk("m_forwardAE", 32'(forwardAE), 32'(e_fae));
      chk("m_forwardBE", 32'(forwardBE), 32'(e_fbe));
      chk("m_forwardAD", 32'(forwardAD), 32'(m_hit(rsD, writeregM, regwriteM)));
      chk("m_forwardBD", 32'(forwardBD), 32'(m_hit(rtD, writeregM, regwriteM)));
      chk("m_stall_flush", {26'd0, stallF, stallD, stallE, flushD, flushE, flushM},
          {26'd0, e_sf, e_sd, e_se, e_fd, e_fe, e_fm});
      chk("m_div_busy", 32'(div_busy), 32'(m_busy_left > 0));
      chk("m_div_done", 32'(div_done), 32'(m_done));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end else begin
      chk("m_rst_outputs", {27'd0, div_busy, div_done, stall_cnt}, 32'd0);
    end
  end

  // driver tasks
  task automatic clear_inputs();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    branchD = 0; jrD = 0; div_startE = 0; exceptM = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    resetn = 0;
    clear_inputs();
    tick();
    resetn = 1;
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    #12;
    chk("rst_div_busy", 32'(div_busy), 32'd0);
    chk("rst_div_done", 32'(div_done), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    resetn = 1;
    tick();

    // forwarding
    rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    settle();
    chk("fwdAE_M_priority", 32'(forwardAE), 32'd2);
    tick();
    rsE = 0;
    settle();
    chk("fwdAE_zero_index", 32'(forwardAE), 32'd0);
    tick();
    rtE = 4; writeregW = 4; regwriteW = 1; writeregM = 9;
    settle();
    chk("fwdBE_W", 32'(forwardBE), 32'd1);
    tick();
    rsD = 6; writeregM = 6; regwriteM = 1;
    settle();
    chk("fwdAD", 32'(forwardAD), 32'd1);
    tick();
    clear_inputs();

    // load-use stall: three cycles, counter climbs 0 -> 3
    memtoregE = 1; regwriteE = 1; writeregE = 5; rtD = 5;
    settle();
    chk("lw_stall_pattern", {28'd0, stallF, stallD, flushE, stallE}, 32'b1110);
    chk("lw_cnt_before", 32'(stall_cnt), 32'd0);
    tick(); tick(); tick();
    chk("lw_cnt_after3", 32'(stall_cnt), 32'd3);
    clear_inputs();
    tick();

    // branch / jump-register dependencies
    jrD = 1; rsD = 7; writeregE = 7; regwriteE = 1;
    settle();
    chk("jr_rs_stall", 32'(stallF), 32'd1);
    tick();
    rsD = 1; rtD = 7;
    settle();
    chk("jr_rt_no_stall", 32'(stallF), 32'd0);
    tick();
    jrD = 0; branchD = 1;
    settle();
    chk("br_rt_stall", 32'(stallF), 32'd1);
    tick();
    clear_inputs();
    branchD = 1; rsD = 9; writeregM = 9; memtoregM = 1;
    tick();
    clear_inputs();
    memtoregE = 1; regwriteE = 1; writeregE = 0; rsD = 0;
    settle();
    chk("lw_index0_no_stall", 32'(stallF), 32'd0);
    tick();
    clear_inputs();

    // exception beats load-use
    memtoregE = 1; regwriteE = 1; writeregE = 5; rsD = 5; exceptM = 1;
    settle();
    chk("exc_over_lw", {26'd0, stallF, stallD, stallE, flushD, flushE, flushM}, 32'b000111);
    tick();
    clear_inputs();

    // divider, 4 stall cycles then done
    do_reset();
    div_startE = 1; memtoregE = 1; regwriteE = 1; writeregE = 5; rsD = 5;
    settle();
    chk("div_start_stall", {26'd0, stallF, stallD, stallE, flushD, flushE, flushM}, 32'b111001);
    chk("div_start_not_busy", 32'(div_busy), 32'd0);
    tick();
    clear_inputs();
    div_startE = 1;
    settle();
    chk("div_busy_c2", 32'(div_busy), 32'd1);
    tick();
    div_startE = 0;
    tick();
    settle();
    chk("div_busy_c4", 32'(stallE), 32'd1);
    tick();
    div_startE = 1;
    settle();
    chk("div_done_c5", {29'd0, div_done, div_busy, stallF}, 32'b100);
    tick();
    div_startE = 0;
    settle();
    chk("div_idle_after", {30'd0, div_done, div_busy}, 32'd0);
    chk("div_cnt", 32'(stall_cnt), 32'd4);
    tick();

    // exception mid-divide
    div_startE = 1;
    tick();
    div_startE = 0;
    tick();
    exceptM = 1;
    settle();
    chk("exc_busy_flush", {26'd0, stallF, stallD, stallE, flushD, flushE, flushM}, 32'b000111);
    tick();
    exceptM = 0;
    settle();
    chk("exc_busy_idle", {30'd0, div_busy, div_done}, 32'd0);
    tick();
    settle();
    chk("exc_no_done", 32'(div_done), 32'd0);
    tick();

    // reset mid-divide
    div_startE = 1;
    tick();
    div_startE = 0;
    tick();
    resetn = 0;
    settle();
    chk("rst_mid_busy", {27'd0, div_busy, stall_cnt}, 32'd0);
    settle();
    resetn = 1;
    tick();
    settle();
    chk("rst_no_done", {30'd0, div_done, div_busy}, 32'd0);
    tick(); tick(); tick();

    // saturation: 20 stall cycles into a 4-bit counter
    do_reset();
    memtoregE = 1; regwriteE = 1; writeregE = 5; rtD = 5;
    for (int i = 0; i < 20; i++) tick();
    chk("cnt_saturate", 32'(stall_cnt), 32'd15);
    clear_inputs();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
